// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUNNING/PAUSED FSM, one-second prescaler and 0..59 seconds counter.
// Optional lap capture is compiled in with STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap,
    input  logic [7:0] minutes_in,
    output logic       lap_valid,
    output logic [5:0] lap_sec,
    output logic [7:0] lap_min,
`endif
    output logic       enable,
    output logic       sec_tick,
    output logic       sec_overflow,
    output logic [5:0] seconds,
    output logic       mins_rst_n,
    output logic [1:0] state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [5:0]      sec_q, sec_d;
    logic            mrn_q;
    logic            tick;

    // A stop in the terminal cycle still lets the tick through; only clear/rst kill it.
    assign tick = !rst && !clear && (state_q == RUNNING) && (presc_q == PRESC_MAX);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sec_d   = sec_q;
        if (clear) begin
            state_d = IDLE;
            presc_d = '0;
            sec_d   = '0;
        end else begin
            unique case (state_q)
                IDLE:    if (start) state_d = RUNNING;
                RUNNING: if (stop)  state_d = PAUSED;
                PAUSED:  if (start) state_d = RUNNING;
                default:            state_d = IDLE;
            endcase
            if (state_q == RUNNING)
                presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
            if (tick)
                sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            sec_q   <= '0;
            mrn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            sec_q   <= sec_d;
            mrn_q   <= !clear;
        end
    end

    assign enable       = (state_q == RUNNING);
    assign sec_tick     = tick;
    assign sec_overflow = tick && (sec_q == 6'd59);
    assign seconds      = sec_q;
    assign mins_rst_n   = mrn_q;
    assign state        = state_q;

`ifdef STOPWATCH_LAP_EN
    logic       lap_valid_q;
    logic [5:0] lap_sec_q;
    logic [7:0] lap_min_q;

    // A second lap releases the frozen display regardless of state.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lap_valid_q <= 1'b0;
            lap_sec_q   <= '0;
            lap_min_q   <= '0;
        end else if (lap) begin
            if (lap_valid_q) begin
                lap_valid_q <= 1'b0;
            end else if (state_q == RUNNING) begin
                lap_valid_q <= 1'b1;
                lap_sec_q   <= sec_q;
                lap_min_q   <= minutes_in;
            end
        end
    end

    assign lap_valid = lap_valid_q;
    assign lap_sec   = lap_sec_q;
    assign lap_min   = lap_min_q;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at TICK_DIV=4: per-cycle expectations queued from a behavioural
// model and compared against the DUT, plus directed checks of the boundary scenarios.
module tb_stopwatch_ctrl;
    localparam int TD = 4;

    typedef struct packed {
        logic [1:0] st;
        logic       en;
        logic       tk;
        logic       ov;
        logic [5:0] sec;
        logic       mrn;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic       enable, sec_tick, sec_overflow, mins_rst_n;
    logic [5:0] seconds;
    logic [1:0] state;
`ifdef STOPWATCH_LAP_EN
    logic       lap = 1'b0;
    logic [7:0] minutes_in = 8'd0;
    logic       lap_valid;
    logic [5:0] lap_sec;
    logic [7:0] lap_min;
`endif

    stopwatch_ctrl #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
        .lap(lap), .minutes_in(minutes_in), .lap_valid(lap_valid),
        .lap_sec(lap_sec), .lap_min(lap_min),
`endif
        .enable(enable), .sec_tick(sec_tick), .sec_overflow(sec_overflow),
        .seconds(seconds), .mins_rst_n(mins_rst_n), .state(state)
    );

    always #5 clk = ~clk;

    int   checks = 0, errors = 0;
    obs_t exp_q[$];
    obs_t g_last;
    int   m_st = 0, m_pr = 0, m_sec = 0;
    logic m_mrn = 1'b0;
    bit   chk_en = 1'b0;
    int   tick_cnt = 0, ovf_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic sa, input logic so, input logic cl);
        obs_t e, p, g;
        logic tk;
        @(negedge clk);
        rst = r; start = sa; stop = so; clear = cl;
        tk    = !r && !cl && (m_st == 1) && (m_pr == TD - 1);
        e.st  = 2'(m_st);
        e.en  = (m_st == 1);
        e.tk  = tk;
        e.ov  = tk && (m_sec == 59);
        e.sec = 6'(m_sec);
        e.mrn = m_mrn;
        if (chk_en) exp_q.push_back(e);
        #2;
        g = {state, enable, sec_tick, sec_overflow, seconds, mins_rst_n};
        g_last = g;
        if (sec_tick) tick_cnt++;
        if (sec_overflow) ovf_cnt++;
        if (exp_q.size() > 0) begin
            p = exp_q.pop_front();
            checks++;
            assert (g === p) else begin
                errors++;
                $error("FAIL cycle_outputs: got %h expected %h (st,en,tk,ov,sec,mrn)", g, p);
            end
        end
        @(posedge clk);
        if (r || cl) begin
            m_st = 0; m_pr = 0; m_sec = 0;
        end else begin
            if (m_st == 1) m_pr = (m_pr == TD - 1) ? 0 : m_pr + 1;
            if (tk) m_sec = (m_sec == 59) ? 0 : m_sec + 1;
            if (m_st == 1 && so) m_st = 2;
            else if (m_st != 1 && sa) m_st = 1;
        end
        m_mrn  = !(r || cl);
        chk_en = 1'b1;
    endtask

    initial begin
        int n;
        // reset, then mins_rst_n low for exactly one further cycle
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("mrn_low_after_rst", 32'(g_last.mrn), 0);
        cyc(0, 0, 1, 0);                       // stop in IDLE ignored
        check("mrn_high_later", 32'(g_last.mrn), 1);
        check("idle_after_stop", 32'(g_last.st), 0);

        // start, run through the 59->0 wrap
        cyc(0, 1, 0, 0);
        tick_cnt = 0; ovf_cnt = 0;
        cyc(0, 0, 0, 0);
        check("enable_after_start", 32'(g_last.en), 1);
        for (int i = 1; i < 245; i++) cyc(0, (i == 20), 0, 0);   // start in RUNNING ignored
        check("tick_count", 32'(tick_cnt), 61);
        check("ovf_count", 32'(ovf_cnt), 1);
        check("sec_after_wrap", 32'(g_last.sec), 1);

        // stop leaves prescaler at 2; seconds frozen; tick on 2nd cycle after resume
        cyc(0, 0, 1, 0);
        tick_cnt = 0;
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
        check("pause_no_tick", 32'(tick_cnt), 0);
        check("pause_state", 32'(g_last.st), 2);
        check("pause_sec_frozen", 32'(g_last.sec), 1);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        check("resume_r1_no_tick", 32'(g_last.tk), 0);
        cyc(0, 0, 0, 0);
        check("resume_r2_tick", 32'(g_last.tk), 1);

        // clear+stop+start at terminal prescaler with seconds=59
        n = 0;
        while (!(m_sec == 59 && m_pr == TD - 1) && n < 1000) begin
            cyc(0, 0, 0, 0);
            n++;
        end
        check("reach_59_bound", 32'(n < 1000), 1);
        cyc(0, 1, 1, 1);
        check("clear_kills_tick", 32'(g_last.tk), 0);
        check("clear_kills_ovf", 32'(g_last.ov), 0);
        cyc(0, 0, 0, 0);
        check("clear_state", 32'(g_last.st), 0);
        check("clear_sec", 32'(g_last.sec), 0);
        check("clear_mrn", 32'(g_last.mrn), 0);

        // rst overrides start mid-run
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        check("rst_midrun_state", 32'(g_last.st), 0);
        check("rst_midrun_sec", 32'(g_last.sec), 0);

`ifdef STOPWATCH_LAP_EN
        cyc(0, 1, 0, 0);
        n = 0;
        while (m_sec != 17 && n < 200) begin
            cyc(0, 0, 0, 0);
            n++;
        end
        lap = 1'b1; minutes_in = 8'd3;
        cyc(0, 0, 0, 0);
        lap = 1'b0; minutes_in = 8'd9;
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
        #1;
        check("lap_valid_set", 32'(lap_valid), 1);
        check("lap_sec", 32'(lap_sec), 17);
        check("lap_min", 32'(lap_min), 3);
        check("lap_sec_advancing", 32'(seconds), 19);
        lap = 1'b1;
        cyc(0, 0, 0, 0);
        lap = 1'b0;
        #1;
        check("lap_valid_cleared", 32'(lap_valid), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
